// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath types and constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package legv8_pkg;

    // Default datapath width.
    localparam int XLEN = 64;

    // Destination select carried with each beat into the 1-to-2 steering stage.
    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } dest_e;

endpackage

// File: rtl/demux_stage_if.sv
// Bundles the producer channel and both consumer channels of demux_stage.
// Latency: n/a (wiring only); slave = the stage, master = its environment.
// Backpressure: valid/ready on every channel; flush is a sideband discard.
// Optional: DEMUX_STATS_EN adds cnt_clr, cnt_a and cnt_b.
interface demux_stage_if import legv8_pkg::*; #(
    parameter int WIDTH = XLEN
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    dest_e            in_sel;
    logic             flush;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
`ifdef DEMUX_STATS_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
`endif

    modport slave (
        input  in_valid, in_data, in_sel, flush, a_ready, b_ready,
`ifdef DEMUX_STATS_EN
        input  cnt_clr,
        output cnt_a, cnt_b,
`endif
        output in_ready, a_valid, a_data, b_valid, b_data
    );

    modport master (
        output in_valid, in_data, in_sel, flush, a_ready, b_ready,
`ifdef DEMUX_STATS_EN
        output cnt_clr,
        input  cnt_a, cnt_b,
`endif
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

endinterface

// File: rtl/demux_stage_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count reflects an increment one cycle after inc.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority; increment stops once the counter reaches all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/demux_stage.sv
// Registered 1-to-2 steering stage: each accepted beat goes to A (sel=0) or B (sel=1).
// Latency: 1 cycle from input handshake to valid on the selected output; 1 beat/cycle.
// Backpressure: single entry, in-order; a stalled head blocks everything behind it.
// Optional: DEMUX_STATS_EN adds saturating per-output fire counters with cnt_clr.
module demux_stage import legv8_pkg::*; #(
    parameter int WIDTH = XLEN
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    demux_stage_if.slave  bus
);

    logic             full_q;
    dest_e            sel_q;
    logic [WIDTH-1:0] data_q;

    logic a_fire;
    logic b_fire;
    logic out_fire;
    logic accept_ok;
    logic in_fire;

    // One shared data register feeds both outputs; only the valids are steered.
    assign bus.a_valid = full_q & (sel_q == DEST_A);
    assign bus.b_valid = full_q & (sel_q == DEST_B);
    assign bus.a_data  = data_q;
    assign bus.b_data  = data_q;

    // The non-selected consumer's ready cannot fire the entry because its valid is low.
    assign a_fire   = bus.a_valid & bus.a_ready;
    assign b_fire   = bus.b_valid & bus.b_ready;
    assign out_fire = a_fire | b_fire;

    // Accept when empty or draining this cycle; flush blocks acceptance.
    // The consumer-ready to in_ready combinational path is deliberate (no bubble).
    assign accept_ok    = ~bus.flush & (~full_q | out_fire);
    assign in_fire      = bus.in_valid & accept_ok;
    // Advertise ready while held in reset; the registers ignore it until release.
    assign bus.in_ready = accept_ok | ~rst_n;

    // Occupancy: flush wins, then a new beat (covers simultaneous drain), then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (bus.flush) begin
            full_q <= 1'b0;
        end else if (in_fire) begin
            full_q <= 1'b1;
        end else if (out_fire) begin
            full_q <= 1'b0;
        end
    end

    // Payload and destination are captured only on an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= DEST_A;
        end else if (in_fire) begin
            data_q <= bus.in_data;
            sel_q  <= bus.in_sel;
        end
    end

`ifdef DEMUX_STATS_EN
    sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr),
        .inc   (a_fire),
        .count (bus.cnt_a)
    );

    sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr),
        .inc   (b_fire),
        .count (bus.cnt_b)
    );
`endif

endmodule

// File: doc/demux_stage.md
Name: demux_stage

Overview:
- Registered 1-to-2 steering stage with valid/ready handshakes; the inverse of the 2:1 select mux.
- One producer channel carries a per-beat destination select. Each accepted beat is delivered to consumer A (sel=0) or consumer B (sel=1).
- Used in the LEGv8 datapath where one result source (e.g. memory response) feeds two sinks (e.g. fetch vs. load writeback).
- One-entry pipeline register; full throughput when the selected consumer is ready.

Parameters:
- WIDTH, 64, data width of the input and both output channels.
- CNT_W, 32, width of the per-output beat counters (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  WIDTH  producer data.
- in_sel  input  1  destination: 0 = A, 1 = B.
- flush  input  1  synchronous discard of the held beat.
- a_valid  output  1  beat valid toward consumer A.
- a_ready  input  1  consumer A accepts.
- a_data  output  WIDTH  data toward A.
- b_valid  output  1  beat valid toward consumer B.
- b_ready  input  1  consumer B accepts.
- b_data  output  WIDTH  data toward B.

Behaviour:
- Reset values:
  - Internal state: full_q=0, sel_q=0, data_q=0.
  - Outputs: a_valid=0, b_valid=0, a_data=0, b_data=0.
  - in_ready=1 while rst_n is low.
  - Reset asserted mid-operation discards the held beat, with no delivery.
- Output decode:
  - a_valid = full_q & ~sel_q; b_valid = full_q & sel_q; never both high.
  - a_data = b_data = data_q (one shared register).
- Firing:
  - out_fire = (a_valid & a_ready) | (b_valid & b_ready). The ready of the non-selected consumer is ignored.
  - in_ready = ~full_q | out_fire. This is a combinational path from a_ready/b_ready to in_ready and is intended.
  - in_fire = in_valid & in_ready.
- Register update, in priority order:
  - flush=1: full_q <= 0; in_ready forced 0 that cycle; in_fire suppressed; data_q and sel_q unchanged.
  - in_fire: data_q <= in_data; sel_q <= in_sel; full_q <= 1. This covers simultaneous out_fire + in_fire (back-to-back, no bubble).
  - out_fire only: full_q <= 0.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to valid on the selected output.
- Throughput: 1 beat/cycle while the selected consumers are ready.
- Ordering: strictly in order. A stalled A beat blocks a following B beat (head-of-line); no bypass.
- Producer obligations:
  - in_data and in_sel are sampled only on in_fire.
  - in_valid may drop without a handshake (no stickiness required of the producer).
- Stability: while a_valid/b_valid is high and not fired, the data and the valid/selected output stay stable.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- When defined:
  - Adds outputs cnt_a and cnt_b, CNT_W each.
  - Counters increment on A-fire and B-fire respectively.
  - They saturate at all-ones and do not wrap.
  - Reset value 0; not affected by flush.
  - Adds input cnt_clr (synchronous clear to 0). When cnt_clr coincides with a fire, the clear wins.
- When undefined: no counter ports or logic exist; the stage behaves identically otherwise.

Decomposition:
- Shared package legv8_pkg gets:
  - typedef enum logic {DEST_A=1'b0, DEST_B=1'b1} dest_e, used for in_sel and sel_q.
  - The default width constant XLEN=64, referenced by WIDTH.
- Natural sub-module: sat_counter (parameter W; ports clk, rst_n, clr, inc, count). It is instantiated twice, only under DEMUX_STATS_EN.

Test Plan:
- Reset, then one beat: in_data=0xDEAD_BEEF, sel=0, a_ready=1.
  - Next cycle a_valid=1, a_data=0xDEAD_BEEF, b_valid=0; entry empty the following cycle.
- Back-to-back alternating sel 0,1,0,1 with data 1..4, both readies held 1.
  - A sees 1,3 and B sees 2,4 on consecutive cycles; in_ready stays 1 throughout.
- Head-of-line: beat 0x11 to A with a_ready=0 for 5 cycles, then beat 0x22 to B with b_ready=1.
  - b_valid stays 0 and in_ready stays 0 until a_ready rises.
  - 0x11 fires, then 0x22 appears on B the next cycle.
- Wrong-side ready: held beat sel=1, a_ready=1, b_ready=0.
  - No fire; b_valid=1 and b_data stable; in_ready=0.
- Flush and reset:
  - flush while holding 0x55 to A: a_valid=0 next cycle, and a simultaneous in_valid is not accepted.
  - rst_n low mid-stall: outputs 0 immediately (asynchronous).
- DEMUX_STATS_EN with CNT_W=4: 20 A-fires give cnt_a=15 (saturated); cnt_clr concurrent with a fire gives cnt_a=0.
